// File: rtl/fetch_unit.sv
// fetch_unit: WISC fetch stage that owns the PC, talks to imem and feeds decode from a small queue.
// Build option FETCH_SKID_EN: two-entry queue (head + skid); default is a single output register.
module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_inc,
    output logic        halted
);
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP      = 16'h0800;
`ifdef FETCH_SKID_EN
    localparam logic [1:0] CAP = 2'd2;
`else
    localparam logic [1:0] CAP = 2'd1;
`endif

    typedef enum logic [1:0] {StFetch, StDrop, StHalt} state_e;
    state_e state_q, state_d;

    logic [15:0] pc_q, pc_d, tgt_q, tgt_d, pc_inc;
    logic        req_q, req_d, halted_q, halted_d;
    logic        hv_q, hv_d;
    logic [15:0] hi_q, hi_d, hp_q, hp_d, hn_q, hn_d;
`ifdef FETCH_SKID_EN
    logic        sv_q, sv_d;
    logic [15:0] si_q, si_d, sp_q, sp_d;
`endif
    logic        redir, xfer, waiting, pop, push, new_req;
    logic [1:0]  occ;

    assign pc_inc  = pc_q + 16'd2;
    assign redir   = redirect && !halted_q;
    assign xfer    = imem_req && imem_rdy;
    assign waiting = imem_req && !imem_rdy;
    assign pop     = hv_q && !stall;
    assign push    = xfer && (state_q == StFetch) && !redir;
`ifdef FETCH_SKID_EN
    assign occ     = {1'b0, hv_q} + {1'b0, sv_q};
`else
    assign occ     = {1'b0, hv_q};
`endif
    // Only raise a request if the slot is certain to be free when the data lands.
    assign new_req = (occ - {1'b0, pop}) < CAP;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StFetch;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (redir) begin
            state_d = waiting ? StDrop : StFetch;
        end else begin
            case (state_q)
                StFetch: if (push && imem_data[15:11] == 5'b00000) state_d = StHalt;
                StDrop:  if (xfer) state_d = StFetch;
                StHalt:  state_d = StHalt;
                default: state_d = StFetch;
            endcase
        end
    end

    // FSM outputs; gated by rst_n so a reset drops the request at once
    always_comb begin
        imem_req = 1'b0;
        if (rst_n) begin
            case (state_q)
                StFetch: imem_req = req_q || new_req;
                StDrop:  imem_req = 1'b1;
                default: imem_req = 1'b0;
            endcase
        end
    end

    // PC and redirect target; in DROP pc_q keeps the outstanding address
    always_comb begin
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        req_d    = waiting;
        halted_d = halted_q || (pop && !redir && hi_q[15:11] == 5'b00000);
        if (redir) begin
            if (waiting) tgt_d = redirect_pc & 16'hFFFE;
            else         pc_d  = redirect_pc & 16'hFFFE;
        end else if (xfer) begin
            pc_d = (state_q == StDrop) ? tgt_q : pc_inc;
        end
    end

    // Instruction queue: pop shifts the skid into the head, push fills the first free slot
    always_comb begin
        hv_d = hv_q;
        hi_d = hi_q;
        hp_d = hp_q;
        hn_d = hn_q;
`ifdef FETCH_SKID_EN
        sv_d = sv_q;
        si_d = si_q;
        sp_d = sp_q;
        if (pop) begin
            hv_d = sv_q;
            sv_d = 1'b0;
            if (sv_q) begin
                hi_d = si_q;
                hp_d = sp_q;
                hn_d = sp_q + 16'd2;
            end
        end
        if (push) begin
            if (hv_d) begin
                sv_d = 1'b1;
                si_d = imem_data;
                sp_d = pc_q;
            end else begin
                hv_d = 1'b1;
                hi_d = imem_data;
                hp_d = pc_q;
                hn_d = pc_inc;
            end
        end
        if (redir) sv_d = 1'b0;
`else
        if (pop) hv_d = 1'b0;
        if (push) begin
            hv_d = 1'b1;
            hi_d = imem_data;
            hp_d = pc_q;
            hn_d = pc_inc;
        end
`endif
        if (redir) hv_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            tgt_q    <= RESET_PC;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
            hv_q     <= 1'b0;
            hi_q     <= NOP;
            hp_q     <= RESET_PC;
            hn_q     <= RESET_PC + 16'd2;
`ifdef FETCH_SKID_EN
            sv_q     <= 1'b0;
            si_q     <= NOP;
            sp_q     <= RESET_PC;
`endif
        end else begin
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            req_q    <= req_d;
            halted_q <= halted_d;
            hv_q     <= hv_d;
            hi_q     <= hi_d;
            hp_q     <= hp_d;
            hn_q     <= hn_d;
`ifdef FETCH_SKID_EN
            sv_q     <= sv_d;
            si_q     <= si_d;
            sp_q     <= sp_d;
`endif
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = hv_q;
    assign if_instr  = hi_q;
    assign if_pc     = hp_q;
    assign if_pc_inc = hn_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit plus a randomized run whose accepted
// instruction stream is checked against an expected-PC scoreboard.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_rdy, stall, redirect, if_valid, halted;
    logic [15:0] imem_addr, imem_data, redirect_pc, if_instr, if_pc, if_pc_inc;

    int          checks = 0;
    int          errors = 0;
    int          nwait = 0;
    int          wcnt = 0;
    bit          rand_mem = 1'b0;
    bit          rnd_bit = 1'b0;
    bit          halt_en = 1'b0;
    logic [15:0] halt_addr = 16'h0010;

`ifdef FETCH_SKID_EN
    localparam int STALL_XFERS = 1;
`else
    localparam int STALL_XFERS = 0;
`endif

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_inc(if_pc_inc), .halted(halted)
    );

    always #5 clk = ~clk;

    // Memory image: opcode 00001 everywhere (word 0 is the NOP 16'h0800), optional HALT
    function automatic logic [15:0] instr_at(input logic [15:0] a);
        if (halt_en && a == halt_addr) return 16'h0123;
        return {5'b00001, a[11:1]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     wcnt <= 0;
        else if (imem_req && !imem_rdy) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
    end
    always @(negedge clk) rnd_bit <= ($urandom % 2) != 0;
    always_comb begin
        imem_data = instr_at(imem_addr);
        imem_rdy  = imem_req && (rand_mem ? rnd_bit : (wcnt >= nwait));
    end

    task automatic do_reset(input int w, input bit h);
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        nwait = w; halt_en = h; rand_mem = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        nwait = 0; halt_en = 1'b0; rand_mem = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h want 0000", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", if_valid); end
        checks++; if (if_instr !== 16'h0800) begin errors++; $display("FAIL rst_instr got %h want 0800", if_instr); end
        checks++; if (if_pc !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h want 0000", if_pc); end
        checks++; if (if_pc_inc !== 16'h0002) begin errors++; $display("FAIL rst_pc_inc got %h want 0002", if_pc_inc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
        do_reset(3, 1'b0);
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            errors++; $display("FAIL first_req got %b/%h want 1/0000", imem_req, imem_addr);
        end
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midreq_reset got %b want 0", imem_req); end
    endtask

    task automatic test_zero_wait();
        logic [15:0] p;
        do_reset(0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            p = 16'(2 * k);
            checks++;
            if ({if_valid, if_pc, if_pc_inc, if_instr} !== {1'b1, p, p + 16'd2, instr_at(p)}) begin
                errors++;
                $display("FAIL zero_wait_%0d got v%b pc %h inc %h ins %h want v1 pc %h inc %h ins %h",
                         k, if_valid, if_pc, if_pc_inc, if_instr, p, p + 16'd2, instr_at(p));
            end
        end
    endtask

    task automatic test_wait_states();
        int          last = 0;
        int          n = 0;
        bit          pw = 1'b0;
        logic [15:0] pa = 16'h0;
        logic [15:0] exp_pc = 16'h0;
        do_reset(2, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #2;
            if (pw) begin
                checks++;
                if ({imem_req, imem_addr} !== {1'b1, pa}) begin
                    errors++; $display("FAIL wait_hold got %b/%h want 1/%h", imem_req, imem_addr, pa);
                end
            end
            if (if_valid) begin
                checks++;
                if (if_pc !== exp_pc) begin errors++; $display("FAIL wait_pc got %h want %h", if_pc, exp_pc); end
                if (n > 0) begin
                    checks++;
                    if (c - last != 3) begin errors++; $display("FAIL wait_rate got %0d want 3", c - last); end
                end
                last = c; n++; exp_pc = exp_pc + 16'd2;
            end
            pw = imem_req && !imem_rdy; pa = imem_addr;
        end
        checks++; if (n < 5) begin errors++; $display("FAIL wait_count got %0d want >=5", n); end
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        int xfers = 0;
        do_reset(0, 1'b0);
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk); #1;
            if (if_valid && if_pc == 16'h0006) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL stall_find got none want pc 0006"); end
        stall = 1'b1; #1;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if ({if_valid, if_pc, if_pc_inc, if_instr} !== {1'b1, 16'h0006, 16'h0008, instr_at(16'h0006)}) begin
                errors++; $display("FAIL stall_frozen got v%b pc %h inc %h want v1 pc 0006 inc 0008",
                                   if_valid, if_pc, if_pc_inc);
            end
            if (imem_req && imem_rdy) begin
                xfers++;
                checks++;
                if (imem_addr !== 16'h0008) begin errors++; $display("FAIL stall_addr got %h want 0008", imem_addr); end
            end
            if (s == 3) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %b want 0", imem_req); end
            end
            @(negedge clk); #2;
        end
        stall = 1'b0; #1;
        checks++; if (xfers != STALL_XFERS) begin errors++; $display("FAIL stall_xfers got %0d want %0d", xfers, STALL_XFERS); end
        @(negedge clk); #1;
        checks++;
        if ({if_valid, if_pc} !== {1'b1, 16'h0008}) begin
            errors++; $display("FAIL stall_release got v%b pc %h want v1 pc 0008", if_valid, if_pc);
        end
        @(negedge clk); #1;
        checks++;
        if ({if_valid, if_pc} !== {1'b1, 16'h000A}) begin
            errors++; $display("FAIL stall_after got v%b pc %h want v1 pc 000a", if_valid, if_pc);
        end
    endtask

    task automatic test_redirect_drop();
        bit found = 1'b0;
        bit seen = 1'b0;
        do_reset(2, 1'b0);
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk); #1;
            if (imem_req && imem_addr == 16'h000A && wcnt == 0) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL drop_find got none want req 000a"); end
        redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk); redirect = 1'b0; #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h000A}) begin
            errors++; $display("FAIL drop_hold got %b/%h want 1/000a", imem_req, imem_addr);
        end
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #1;
            if (if_valid) begin
                seen = 1'b1;
                checks++;
                if ({if_pc, if_instr} !== {16'h0040, instr_at(16'h0040)}) begin
                    errors++; $display("FAIL drop_next got pc %h ins %h want pc 0040 ins %h",
                                       if_pc, if_instr, instr_at(16'h0040));
                end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL drop_timeout got none want pc 0040"); end
    endtask

    task automatic test_wrap();
        do_reset(0, 1'b0);
        repeat (3) @(negedge clk);
        #1 redirect = 1'b1; redirect_pc = 16'hFFFE;
        @(negedge clk); redirect = 1'b0; #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'hFFFE}) begin
            errors++; $display("FAIL redir_addr got %b/%h want 1/fffe", imem_req, imem_addr);
        end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", if_valid); end
        @(negedge clk); #1;
        checks++;
        if ({if_valid, if_pc, if_pc_inc, if_instr} !== {1'b1, 16'hFFFE, 16'h0000, instr_at(16'hFFFE)}) begin
            errors++; $display("FAIL wrap_fffe got v%b pc %h inc %h want v1 pc fffe inc 0000",
                               if_valid, if_pc, if_pc_inc);
        end
        @(negedge clk); #1;
        checks++;
        if ({if_valid, if_pc, if_pc_inc, if_instr} !== {1'b1, 16'h0000, 16'h0002, instr_at(16'h0000)}) begin
            errors++; $display("FAIL wrap_0000 got v%b pc %h inc %h want v1 pc 0000 inc 0002",
                               if_valid, if_pc, if_pc_inc);
        end
    endtask

    task automatic test_halt();
        bit found = 1'b0;
        bit seen = 1'b0;
        int reqs = 0;
        do_reset(0, 1'b1);
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk); #1;
            if (if_valid && if_pc == 16'h0010) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL halt_find got none want pc 0010"); end
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_noreq got %b want 0", imem_req); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b want 0", halted); end
        @(negedge clk); #1;
        checks++;
        if ({halted, if_valid} !== 2'b10) begin
            errors++; $display("FAIL halt_set got halted %b valid %b want 1 0", halted, if_valid);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            redirect = (c == 1); redirect_pc = 16'h0020; #1;
            if (imem_req) reqs++;
        end
        redirect = 1'b0;
        checks++; if (reqs != 0) begin errors++; $display("FAIL halt_stop got %0d reqs want 0", reqs); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b want 1", halted); end

        // HALT squashed by a redirect before decode takes it
        do_reset(0, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk); #1;
            if (if_valid && if_pc == 16'h0010) found = 1'b1;
        end
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0020;
        @(negedge clk); redirect = 1'b0; stall = 1'b0; #1;
        checks++;
        if ({imem_req, imem_addr, halted, if_valid} !== {1'b1, 16'h0020, 1'b0, 1'b0}) begin
            errors++; $display("FAIL halt_squash got req %b addr %h halted %b valid %b want 1 0020 0 0",
                               imem_req, imem_addr, halted, if_valid);
        end
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk); #1;
            if (if_valid) begin
                seen = 1'b1;
                checks++; if (if_pc !== 16'h0020) begin errors++; $display("FAIL halt_resume got %h want 0020", if_pc); end
            end
        end
        checks++; if (!seen || halted !== 1'b0) begin errors++; $display("FAIL halt_resume_end got seen %b halted %b want 1 0", seen, halted); end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc = 16'h0;
        logic [15:0] pa = 16'h0;
        bit          pw = 1'b0;
        int          n = 0;
        do_reset(0, 1'b0);
        rand_mem = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            stall       = ($urandom % 4) == 0;
            redirect    = ($urandom % 20) == 0;
            redirect_pc = 16'($urandom);
            #1;
            if (pw) begin
                checks++;
                if ({imem_req, imem_addr} !== {1'b1, pa}) begin
                    errors++; $display("FAIL rand_hold got %b/%h want 1/%h", imem_req, imem_addr, pa);
                end
            end
            if (imem_req) begin
                checks++; if (imem_addr[0] !== 1'b0) begin errors++; $display("FAIL rand_even got %h want even", imem_addr); end
            end
            if (if_valid && !stall) begin
                checks++;
                if ({if_pc, if_instr, if_pc_inc} !== {exp_pc, instr_at(exp_pc), exp_pc + 16'd2}) begin
                    errors++; $display("FAIL rand_stream got pc %h ins %h inc %h want pc %h ins %h inc %h",
                                       if_pc, if_instr, if_pc_inc, exp_pc, instr_at(exp_pc), exp_pc + 16'd2);
                end
                exp_pc = exp_pc + 16'd2;
                n++;
            end
            if (redirect) exp_pc = redirect_pc & 16'hFFFE;
            pw = imem_req && !imem_rdy && !redirect;
            pa = imem_addr;
        end
        redirect = 1'b0; stall = 1'b0;
        checks++; if (n < 300) begin errors++; $display("FAIL rand_progress got %0d want >=300", n); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_drop();
        test_wrap();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
